// File: rtl/usb_bridge_pkg.sv
// Shared constants and types for the USB CDC bridges (word TX return path and UART bridge).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package usb_bridge_pkg;

  localparam int BYTE_W         = 8;
  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;

  localparam logic [BYTE_W-1:0] DEFAULT_HEADER_BYTE = 8'hA5;

  // Serializer states: IDLE waits for a word, HDR presents the framing byte,
  // DATA walks the four payload bytes.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } bridge_state_e;

  // Byte idx of a word in transmit order; idx 0 is the first byte on the wire.
  function automatic logic [BYTE_W-1:0] word_byte(input logic [WORD_W-1:0] word,
                                                  input logic [1:0]        idx,
                                                  input logic              msb_first);
    logic [1:0] lane;
    lane = msb_first ? (2'd3 - idx) : idx;
    return word[BYTE_W*lane +: BYTE_W];
  endfunction

endpackage

// File: rtl/usb_word_tx_bridge_word_fifo.sv
// Synchronous first-word-fall-through FIFO; pop_data_o shows the head entry whenever !empty_o.
// Latency: a pushed entry is visible on pop_data_o the cycle after the push edge.
// Backpressure: push ignored while full_o, pop ignored while empty_o.
// Ports: clk_i/reset_n_i (async active-low), push_i/push_data_i, pop_i/pop_data_o, full_o, empty_o.
module word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full_o     = (count == DEPTH_CNT);
  assign empty_o    = (count == '0);
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign pop_data_o = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_data_i;
  end

endmodule

// File: rtl/usb_word_tx_bridge.sv
// Serializes buffered 32-bit words into the CDC IN byte stream, optional header byte per word.
// Latency: word pushed at edge N into an idle bridge -> first byte valid after edge N+1; no bubbles between words.
// Backpressure: in_ready_i low holds in_valid_o/in_data_o; word_ready_o drops when the word FIFO is full.
// Ports: clk_i, reset_n_i (async active-low); word_data_i/word_valid_i/word_ready_o (word side);
//        in_data_o/in_valid_o/in_ready_i (usb_cdc IN side); busy_o; words_sent_o (16-bit wrapping count).
module usb_word_tx_bridge
  import usb_bridge_pkg::*;
#(
  parameter int         FIFO_DEPTH  = 4,
  parameter int         MSB_FIRST   = 1,
  parameter int         HEADER_EN   = 0,
  parameter logic [7:0] HEADER_BYTE = DEFAULT_HEADER_BYTE
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic [31:0] word_data_i,
  input  logic        word_valid_i,
  output logic        word_ready_o,
  output logic [7:0]  in_data_o,
  output logic        in_valid_o,
  input  logic        in_ready_i,
  output logic        busy_o,
  output logic [15:0] words_sent_o
);

  localparam logic MSB_SEL = (MSB_FIRST != 0);
  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_pop;
  logic [31:0] fifo_rd_data;

  bridge_state_e state_q, state_d;
  logic [31:0]   shift_q, shift_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic          in_valid_q, in_valid_d;
  logic [7:0]    in_data_q, in_data_d;
  logic [15:0]   words_sent_q, words_sent_d;
  logic          handshake;
  logic          load_word;

  word_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_word_fifo (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .push_i      (word_valid_i),
    .push_data_i (word_data_i),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_rd_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign word_ready_o = !fifo_full;
  assign busy_o       = !fifo_empty || (state_q != ST_IDLE);
  assign in_valid_o   = in_valid_q;
  assign in_data_o    = in_data_q;
  assign words_sent_o = words_sent_q;
  assign handshake    = in_valid_q && in_ready_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      byte_idx_q   <= '0;
      in_valid_q   <= 1'b0;
      in_data_q    <= '0;
      words_sent_q <= '0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      byte_idx_q   <= byte_idx_d;
      in_valid_q   <= in_valid_d;
      in_data_q    <= in_data_d;
      words_sent_q <= words_sent_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    byte_idx_d   = byte_idx_q;
    in_valid_d   = in_valid_q;
    in_data_d    = in_data_q;
    words_sent_d = words_sent_q;
    fifo_pop     = 1'b0;
    load_word    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) load_word = 1'b1;
      end
      ST_HDR: begin
        if (handshake) begin
          state_d   = ST_DATA;
          in_data_d = word_byte(shift_q, 2'd0, MSB_SEL);
        end
      end
      ST_DATA: begin
        if (handshake) begin
          if (byte_idx_q == LAST_IDX) begin
            words_sent_d = words_sent_q + 16'd1;
            // Chain straight into the next buffered word so the stream has no gap.
            if (!fifo_empty) begin
              load_word = 1'b1;
            end else begin
              state_d    = ST_IDLE;
              in_valid_d = 1'b0;
            end
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
            in_data_d  = word_byte(shift_q, byte_idx_q + 2'd1, MSB_SEL);
          end
        end
      end
      default: begin
        state_d    = ST_IDLE;
        in_valid_d = 1'b0;
      end
    endcase

    // Pull the FIFO head into the shift register and present its first byte.
    if (load_word) begin
      fifo_pop   = 1'b1;
      shift_d    = fifo_rd_data;
      byte_idx_d = 2'd0;
      in_valid_d = 1'b1;
      if (HEADER_EN != 0) begin
        state_d   = ST_HDR;
        in_data_d = HEADER_BYTE;
      end else begin
        state_d   = ST_DATA;
        in_data_d = word_byte(fifo_rd_data, 2'd0, MSB_SEL);
      end
    end
  end

endmodule
